// File: rtl/rf_wb_sched.sv
// rf_wb_sched: write-port scheduler and long-latency scoreboard for the
// pipeline register file. The in-order writeback always wins the single
// write port; long-unit results take the port on free cycles. Registers
// with outstanding long writes are tracked so that decode stalls on RAW/WAW.
// Optional: define RF_WB_SKID_EN to add a one-entry skid buffer that lets
// the long unit hand off a result even while the pipeline owns the port.
module rf_wb_sched #(
    parameter int PEND_MAX = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Run,
    input  logic        IssueValid,
    input  logic [4:0]  IssueRs,
    input  logic [4:0]  IssueRt,
    input  logic        IssueUseRs,
    input  logic        IssueUseRt,
    input  logic [4:0]  IssueRw,
    input  logic        IssueWr,
    input  logic        IssueLong,
    output logic        Stall,
    input  logic        PipeWr,
    input  logic [4:0]  PipeRw,
    input  logic [31:0] PipeBusW,
    input  logic        LongValid,
    input  logic [4:0]  LongRw,
    input  logic [31:0] LongData,
    output logic        LongReady,
    output logic        RegWr,
    output logic [4:0]  Rw,
    output logic [31:0] busW
);

    localparam int CW = $clog2(PEND_MAX + 1);

    logic [31:1]   r_pend;
    logic [CW-1:0] r_cnt;

    logic [31:0]   w_pendVec;
    logic          w_raw;
    logic          w_waw;
    logic          w_full;
    logic          w_accept;
    logic          w_longInc;
    logic          w_longFire;
    logic          w_commit;
    logic [4:0]    w_commitAddr;
    logic [31:0]   w_commitData;
    logic          w_commitErr;
    logic [CW-1:0] w_cntNext;
    logic [31:1]   w_pendNext;

    // Register 0 is never pending; a zero LSB lets any 5-bit address index directly.
    assign w_pendVec = {r_pend, 1'b0};

    assign w_raw  = (IssueUseRs & w_pendVec[IssueRs]) | (IssueUseRt & w_pendVec[IssueRt]);
    assign w_waw  = IssueWr & w_pendVec[IssueRw];
    assign w_full = IssueLong & IssueWr & (r_cnt == CW'(PEND_MAX));

    // Hazards look only at registered state, so a commit frees the issue one cycle later.
    assign Stall     = ~Run | (IssueValid & (w_raw | w_waw | w_full));
    assign w_accept  = IssueValid & ~Stall & Run;
    assign w_longInc = w_accept & IssueLong & IssueWr;

`ifdef RF_WB_SKID_EN
    logic        r_bufFull;
    logic [4:0]  r_bufAddr;
    logic [31:0] r_bufData;
    logic        w_capture;
    logic        w_drain;

    // A full buffer blocks the long unit, which also keeps the drain cycle to one long write.
    assign LongReady    = Run & ~r_bufFull;
    assign w_longFire   = LongValid & LongReady;
    assign w_capture    = w_longFire & PipeWr;
    assign w_drain      = Run & r_bufFull & ~PipeWr;
    assign w_commit     = w_drain | (w_longFire & ~PipeWr);
    assign w_commitAddr = r_bufFull ? r_bufAddr : LongRw;
    assign w_commitData = r_bufFull ? r_bufData : LongData;

    // Skid entry: filled when the pipeline holds the port, emptied on the first free cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_bufFull <= 1'b0;
            r_bufAddr <= 5'd0;
            r_bufData <= 32'd0;
        end else if (w_capture) begin
            r_bufFull <= 1'b1;
            r_bufAddr <= LongRw;
            r_bufData <= LongData;
        end else if (w_drain) begin
            r_bufFull <= 1'b0;
        end
    end
`else
    // Without a buffer the long unit simply waits for a cycle the pipeline leaves free.
    assign LongReady    = Run & ~PipeWr;
    assign w_longFire   = LongValid & LongReady;
    assign w_commit     = w_longFire;
    assign w_commitAddr = LongRw;
    assign w_commitData = LongData;
`endif

    // Committing to an idle register or with nothing outstanding is a protocol error.
    assign w_commitErr = w_commit &
                         (((w_commitAddr != 5'd0) & ~w_pendVec[w_commitAddr]) | (r_cnt == '0));

    // Write port mux: pipeline first, long source second; address 0 is never written.
    always_comb begin
        RegWr = 1'b0;
        Rw    = 5'd0;
        busW  = 32'd0;
        if (Run) begin
            if (PipeWr) begin
                Rw    = PipeRw;
                busW  = PipeBusW;
                RegWr = (PipeRw != 5'd0);
            end else if (w_commit) begin
                Rw    = w_commitAddr;
                busW  = w_commitData;
                RegWr = (w_commitAddr != 5'd0);
            end
        end
    end

    // Outstanding count: issue adds, commit removes, never wrapping below zero.
    always_comb begin
        w_cntNext = r_cnt;
        if (w_longInc) begin
            w_cntNext = w_cntNext + CW'(1);
        end
        if (w_commit && (r_cnt != '0)) begin
            w_cntNext = w_cntNext - CW'(1);
        end
    end

    // Pending bits: clear on a clean commit, set on a long issue; WAW keeps them disjoint.
    always_comb begin
        w_pendNext = r_pend;
        for (int i = 1; i < 32; i++) begin
            if (w_commit && !w_commitErr && (w_commitAddr == 5'(i))) begin
                w_pendNext[i] = 1'b0;
            end
            if (w_longInc && (IssueRw == 5'(i))) begin
                w_pendNext[i] = 1'b1;
            end
        end
    end

    // Scoreboard state is frozen while Run is low and flushed by reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_pend <= '0;
            r_cnt  <= '0;
        end else if (Run) begin
            r_pend <= w_pendNext;
            r_cnt  <= w_cntNext;
        end
    end

`ifndef SYNTHESIS
    logic sticky_err;

    // Sticky record of any bad commit, for inspection in simulation.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sticky_err <= 1'b0;
        end else if (Run && w_commitErr) begin
            sticky_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Write-port scheduler and scoreboard in front of the pipeline register file.
- The register file has one write port, written on posedge Clk while Run is high.
- Two writers share that port: the in-order pipeline writeback, which is fixed-latency and cannot stall, and a long-latency unit (mul/div) that returns results out of band.
- The block arbitrates the port, tracks registers with outstanding long-latency writes, and stalls issue on RAW/WAW hazards against them.

Parameters:
- PEND_MAX, 4: max outstanding long-latency ops in flight; legal range 1..15.

Ports:
- Clk  in  1  pipeline clock; all state updates on posedge.
- Rst  in  1  asynchronous, active-high reset.
- Run  in  1  global run enable; state frozen when low.
- IssueValid  in  1  instruction at decode requests issue this cycle.
- IssueRs  in  5  source register A.
- IssueRt  in  5  source register B.
- IssueUseRs  in  1  IssueRs is actually read.
- IssueUseRt  in  1  IssueRt is actually read.
- IssueRw  in  5  destination register.
- IssueWr  in  1  instruction writes IssueRw.
- IssueLong  in  1  destination is produced by the long-latency unit.
- Stall  out  1  hold decode; the issue is not accepted this cycle.
- PipeWr  in  1  pipeline writeback valid.
- PipeRw  in  5  pipeline writeback address.
- PipeBusW  in  32  pipeline writeback data.
- LongValid  in  1  long unit offers a result.
- LongRw  in  5  long result address.
- LongData  in  32  long result data.
- LongReady  out  1  long result accepted when LongValid and LongReady are both high.
- RegWr  out  1  register file write enable.
- Rw  out  5  register file write address.
- busW  out  32  register file write data.

Behaviour:
- State:
  - Pend[31:1]: pending bits; there is no bit for register 0.
  - Cnt: outstanding long-op count, $clog2(PEND_MAX+1) bits wide.
  - Optional skid buffer (see Optional Feature).
- Reset: Pend=0, Cnt=0, buffer empty. Resulting outputs: Stall=0, LongReady=1, RegWr=0, Rw=0, busW=0.
- Hazard:
  - Stall = IssueValid & (RAW | WAW | FULL).
  - RAW = (IssueUseRs & Pend[IssueRs]) | (IssueUseRt & Pend[IssueRt]).
  - WAW = IssueWr & Pend[IssueRw].
  - FULL = IssueLong & IssueWr & (Cnt==PEND_MAX).
  - Uses registered Pend only; a commit in cycle N releases a stalled issue in cycle N+1.
- Issue accept: IssueValid & ~Stall & Run.
  - If the accepted issue also has IssueLong & IssueWr & IssueRw!=0: set Pend[IssueRw] and Cnt+1.
  - IssueLong with IssueRw==0 still increments Cnt.
- Write port (combinational, zero latency, same-cycle grant):
  - Priority 1: PipeWr. It drives Rw=PipeRw, busW=PipeBusW.
  - Priority 2: long source, i.e. the buffer if it is occupied, else the direct LongValid handshake.
  - No source: RegWr=0, Rw=0, busW=0.
  - Any write with address 0 is dropped: RegWr=0. Pend and Cnt still update for a long commit to 0.
- Long commit: a long result granted the port. It clears Pend[addr] and decrements Cnt.
- Same cycle issue-set and commit-clear: a set of register X cannot coincide with a clear of X, because the set is blocked by WAW. If Cnt is both incremented and decremented, the net change is 0.
- Run low:
  - RegWr=0, LongReady=0, Stall=1.
  - Pend, Cnt and buffer hold.
- Rst mid-operation: all state clears immediately; in-flight long results are lost (system-level flush).
- Errors:
  - Long commit with Pend[addr]==0, or while Cnt==0: Cnt saturates at 0 and Pend is unchanged.
  - The simulation-only error flag sticky_err is set and held until Rst.

Optional Feature:
- Macro: RF_WB_SKID_EN.
- Defined: a one-entry 37-bit skid buffer (addr and data) for the long source.
  - LongReady = Run & ~BufFull.
  - A long result accepted while PipeWr=1 is captured into the buffer.
  - The buffer drains on the first cycle with PipeWr=0. In that cycle LongReady=0 if a new LongValid would also need the port, so there is one long write per cycle at most.
  - Buffer-resident results keep Pend set until drained.
- Undefined: no buffer.
  - LongReady = Run & ~PipeWr.
  - The long unit holds LongValid and its data until granted.

Test Plan:
- Rst pulse mid-cycle with Pend[5]=1, Cnt=1 -> immediately Pend=0, Cnt=0, Stall=0, RegWr=0.
- Issue long write r8 (IssueLong=1, IssueRw=8), then an issue reading Rs=8 -> Stall=1 until LongValid, LongRw=8, LongData=0xDEADBEEF commits. Expect RegWr=1, Rw=8, busW=0xDEADBEEF, then Stall=0 the next cycle.
- PipeWr=1 (PipeRw=3, data 0x11) and LongValid=1 (LongRw=9) in the same cycle:
  - Expect Rw=3 that cycle.
  - Without macro: LongReady=0; after PipeWr drops, Rw=9.
  - With macro: LongReady=1, result buffered, Rw=9 on the next free cycle.
- Issue PEND_MAX=4 long ops to r1..r4, then a 5th long op -> Stall=1 (FULL) until one commit; Cnt never exceeds 4.
- PipeWr=1, PipeRw=0, data 0xFFFFFFFF -> RegWr=0. Long commit to r0 -> RegWr=0 and Cnt decremented.
- Run=0 with LongValid=1 and PipeWr=1 -> RegWr=0, LongReady=0, Stall=1; Pend/Cnt unchanged. Run=1 resumes the arbitration above.
